// File: rtl/dsn_pkg.sv
// dsn_pkg: shared op codes, 1-wire constants and FSM encodings for the DSN master
package dsn_pkg;
  typedef enum logic [1:0] {OP_INIT = 2'd0, OP_WR = 2'd1, OP_RD = 2'd2, OP_ROM = 2'd3} op_e;
  localparam logic [7:0] ROM_CMD  = 8'h33;
  localparam logic [7:0] CRC_POLY = 8'h8C;
  typedef enum logic [2:0] {
    S_IDLE, S_RST_LO, S_RST_REL, S_SLOT_LO, S_SLOT_SMP, S_SLOT_END, S_NEXT, S_UNSTART
  } state_e;
endpackage

// File: rtl/dsn_crc8.sv
// dsn_crc8: reflected Dallas CRC-8 accumulator, one bit per shift_en
module dsn_crc8 import dsn_pkg::*; (
  input  logic       clock,
  input  logic       global_reset_n,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       bit_in,
  output logic [7:0] crc
);
  logic [7:0] crc_q, crc_d;
  always_comb
    crc_d = clear ? 8'h00 : shift_en ? (crc_q >> 1) ^ ((crc_q[0] ^ bit_in) ? CRC_POLY : 8'h00) : crc_q;
  always_ff @(posedge clock or negedge global_reset_n)
    if (!global_reset_n) crc_q <= 8'h00;
    else crc_q <= crc_d;
  assign crc = crc_q;
endmodule

// File: rtl/dsn_multi.sv
// dsn_multi: multi-channel 1-wire DSN master with single-slot ops and autonomous ROM read
module dsn_multi import dsn_pkg::*; #(
  parameter int MXCH      = 3,
  parameter int MXCHB     = 2,
  parameter int MXCNT     = 16,
  parameter int CNT_INIT  = 15,
  parameter int CNT_PRES  = 11,
  parameter int CNT_SLOT  = 13,
  parameter int CNT_LONG  = 12,
  parameter int CNT_SHORT = 6,
  parameter int CNT_READ  = 8
) (
  input  logic             clock,
  input  logic             global_reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             wr_data,
  input  logic [MXCHB-1:0] channel,
  input  logic [MXCH-1:0]  dsn_in,
  output logic [MXCH-1:0]  dsn_out,
  output logic             busy,
  output logic             done,
  output logic             rd_data,
  output logic             present,
  output logic [63:0]      rom_data,
  output logic             crc_ok,
  output logic             sel_err
);
  // Each boundary is the last clock of a 2^N-clock phase
  localparam logic [MXCNT-1:0] T_INIT  = MXCNT'((64'd1 << CNT_INIT) - 64'd1);
  localparam logic [MXCNT-1:0] T_PRES  = MXCNT'((64'd1 << CNT_PRES) - 64'd1);
  localparam logic [MXCNT-1:0] T_SLOT  = MXCNT'((64'd1 << CNT_SLOT) - 64'd1);
  localparam logic [MXCNT-1:0] T_LONG  = MXCNT'((64'd1 << CNT_LONG) - 64'd1);
  localparam logic [MXCNT-1:0] T_SHORT = MXCNT'((64'd1 << CNT_SHORT) - 64'd1);
  localparam logic [MXCNT-1:0] T_READ  = MXCNT'((64'd1 << CNT_READ) - 64'd1);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [MXCNT-1:0] cnt_q, cnt_d;
  logic [MXCHB-1:0] ch_q, ch_d;
  logic [MXCH-1:0] out_q, out_d;
  logic [6:0] idx_q, idx_d;
  logic [63:0] rom_q, rom_d;
  logic wr_q, wr_d, rd_ph_q, rd_ph_d, smp_q, smp_d, done_q, done_d;
  logic rd_data_q, rd_data_d, present_q, present_d, crc_ok_q, crc_ok_d, sel_err_q, sel_err_d;
  logic crc_clr, crc_sh, line, slot_bit, rd_slot;
  logic [7:0] crc;
  dsn_crc8 u_crc (
    .clock(clock), .global_reset_n(global_reset_n), .clear(crc_clr),
    .shift_en(crc_sh), .bit_in(line), .crc(crc)
  );
  assign line     = dsn_in[ch_q];
  assign slot_bit = (op_q == OP_WR) ? wr_q : (op_q == OP_ROM && !rd_ph_q) ? ROM_CMD[idx_q[2:0]] : 1'b1;
  assign rd_slot  = (op_q == OP_RD) || (op_q == OP_ROM && rd_ph_q);
  assign busy     = !(state_q inside {S_IDLE, S_UNSTART});
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = busy ? cnt_q + 1'b1 : cnt_q;
    ch_d = ch_q;
    idx_d = idx_q;
    rom_d = rom_q;
    wr_d = wr_q;
    rd_ph_d = rd_ph_q;
    smp_d = smp_q;
    rd_data_d = rd_data_q;
    present_d = present_q;
    crc_ok_d = crc_ok_q;
    sel_err_d = sel_err_q;
    crc_clr = 1'b0;
    crc_sh = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        op_d = op_e'(op);
        wr_d = wr_data;
        ch_d = channel;
        sel_err_d = 1'b0;
        present_d = 1'b0;
        crc_ok_d = 1'b0;
        cnt_d = '0;
        if (int'(channel) >= MXCH) begin
          sel_err_d = 1'b1;
          state_d = S_UNSTART;
        end else begin
          rom_d = (op == OP_ROM) ? 64'd0 : rom_q;
          crc_clr = 1'b1;
          idx_d = '0;
          rd_ph_d = 1'b0;
          state_d = (op == OP_INIT || op == OP_ROM) ? S_RST_LO : S_SLOT_LO;
        end
      end
      S_RST_LO: if (cnt_q == T_INIT) begin
        cnt_d = '0;
        state_d = S_RST_REL;
      end
      S_RST_REL: begin
        if (cnt_q == T_PRES) begin
          present_d = ~line;
          rd_data_d = ~line;
        end
        if (cnt_q == T_INIT) begin
          cnt_d = '0;
          state_d = (op_q == OP_ROM && present_q) ? S_SLOT_LO : S_UNSTART;
        end
      end
      S_SLOT_LO: if (cnt_q == (slot_bit ? T_SHORT : T_LONG)) state_d = S_SLOT_SMP;
      // Read slots sample after release; the chip holds the line low for a 0
      S_SLOT_SMP: if (!rd_slot) state_d = S_SLOT_END;
      else if (cnt_q == T_READ) begin
        smp_d = line;
        rd_data_d = (op_q == OP_RD) ? line : rd_data_q;
        crc_sh = (op_q == OP_ROM);
        state_d = S_SLOT_END;
      end
      S_SLOT_END: if (cnt_q == T_SLOT) state_d = S_NEXT;
      S_NEXT: begin
        cnt_d = '0;
        if (op_q != OP_ROM) state_d = S_UNSTART;
        else if (!rd_ph_q) begin
          rd_ph_d = (idx_q == 7'd7);
          idx_d = (idx_q == 7'd7) ? 7'd0 : idx_q + 7'd1;
          state_d = S_SLOT_LO;
        end else begin
          rom_d[idx_q[5:0]] = smp_q;
          idx_d = idx_q + 7'd1;
          crc_ok_d = (idx_q == 7'd63) ? (crc == 8'h00) : crc_ok_q;
          state_d = (idx_q == 7'd63) ? S_UNSTART : S_SLOT_LO;
        end
      end
      S_UNSTART: if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_UNSTART) && (state_q != S_UNSTART);
    out_d = ~(MXCH'(state_d == S_RST_LO || state_d == S_SLOT_LO) << ch_d);
  end
  always_ff @(posedge clock or negedge global_reset_n)
    if (!global_reset_n) begin
      state_q <= S_IDLE;
      op_q <= OP_INIT;
      cnt_q <= '0;
      ch_q <= '0;
      out_q <= '1;
      idx_q <= '0;
      rom_q <= '0;
      wr_q <= 1'b0;
      rd_ph_q <= 1'b0;
      smp_q <= 1'b0;
      done_q <= 1'b0;
      rd_data_q <= 1'b0;
      present_q <= 1'b0;
      crc_ok_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      ch_q <= ch_d;
      out_q <= out_d;
      idx_q <= idx_d;
      rom_q <= rom_d;
      wr_q <= wr_d;
      rd_ph_q <= rd_ph_d;
      smp_q <= smp_d;
      done_q <= done_d;
      rd_data_q <= rd_data_d;
      present_q <= present_d;
      crc_ok_q <= crc_ok_d;
      sel_err_q <= sel_err_d;
    end
  assign dsn_out  = out_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign present  = present_q;
  assign rom_data = rom_q;
  assign crc_ok   = crc_ok_q;
  assign sel_err  = sel_err_q;
endmodule

// File: tb/tb_dsn_multi.sv
// tb_dsn_multi: scoreboard bench for dsn_multi with a behavioural DSN chip on channel 1
`timescale 1ns/1ps
module tb_dsn_multi;
  localparam logic [63:0] ROM  = 64'hA200000001B81C02;
  localparam logic [63:0] ROMF = 64'hA200000001A81C02;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, start, wr_data, busy, done, rd_data, present, crc_ok, sel_err;
  logic [1:0] op, channel;
  logic [2:0] dsn_in, dsn_out, drv;
  logic [63:0] rom_data;
  // Short phases: init 128, presence 32, slot 32, write-0 16, write-1 4, read sample 8
  dsn_multi #(.MXCH(3), .MXCHB(2), .MXCNT(16), .CNT_INIT(7), .CNT_PRES(5), .CNT_SLOT(5),
              .CNT_LONG(4), .CNT_SHORT(2), .CNT_READ(3)) dut (
    .clock(clk), .global_reset_n(rst_n), .start(start), .op(op), .wr_data(wr_data),
    .channel(channel), .dsn_in(dsn_in), .dsn_out(dsn_out), .busy(busy), .done(done),
    .rd_data(rd_data), .present(present), .rom_data(rom_data), .crc_ok(crc_ok), .sel_err(sel_err)
  );
  // Chip model: presence after a long low, records 8 command bits, then answers 64 read slots
  logic chip_en = 1'b0, hold_low = 1'b0, prev = 1'b1, in_slot = 1'b0;
  logic [63:0] rom_m = ROM;
  logic [7:0] cmd = 8'h00;
  int mlow = 0, st = 0, bitn = 72, pres_cnt = 0;
  assign drv = {1'b0, (chip_en && pres_cnt > 0) || hold_low ||
                (chip_en && in_slot && bitn >= 8 && bitn < 72 && !rom_m[(bitn - 8) & 63] && st < 12), 1'b0};
  assign dsn_in = dsn_out & ~drv;
  always @(posedge clk) begin
    prev <= dsn_out[1];
    mlow <= dsn_out[1] ? 0 : mlow + 1;
    if (pres_cnt > 0) pres_cnt <= pres_cnt - 1;
    if (prev && !dsn_out[1]) begin
      st <= 0;
      in_slot <= 1'b1;
    end else st <= st + 1;
    if (!prev && dsn_out[1] && mlow > 64 && chip_en) begin
      pres_cnt <= 48;
      bitn <= 0;
    end
    if (in_slot && st == 10 && bitn < 8) cmd[bitn] <= dsn_in[1];
    if (in_slot && st == 12) begin
      bitn <= bitn + 1;
      in_slot <= 1'b0;
    end
  end
  typedef struct {string nm; logic pres, rd, crc, sel; logic [63:0] rom;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, m_chk = 0, m_fail = 0;
  logic mon_last = 1'b0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic mchk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    m_chk++;
    if (act !== exp) begin
      m_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic push(input string nm, input logic p, input logic r, input logic c, input logic s, input logic [63:0] rm);
    exp_t e;
    e.nm = nm; e.pres = p; e.rd = r; e.crc = c; e.sel = s; e.rom = rm;
    sb.push_back(e);
  endtask
  // Monitor: every done pulse consumes one expectation; done must last a single clock
  initial forever begin
    @(negedge clk);
    if (mon_last) mchk("done width", 64'(done), 64'd0);
    if (done) begin
      if (sb.size() == 0) begin
        m_chk++;
        m_fail++;
        $display("FAIL unexpected done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb.pop_front();
        mchk({e.nm, " present"}, 64'(present), 64'(e.pres));
        mchk({e.nm, " rd_data"}, 64'(rd_data), 64'(e.rd));
        mchk({e.nm, " crc_ok"}, 64'(crc_ok), 64'(e.crc));
        mchk({e.nm, " sel_err"}, 64'(sel_err), 64'(e.sel));
        mchk({e.nm, " rom_data"}, rom_data, e.rom);
      end
    end
    mon_last = done;
  end
  task automatic run_op(input logic [1:0] o, input logic w, input logic [1:0] ch, input int budget,
                        input bit hold, output int cyc, output int lows, output int falls, output bit other);
    logic p;
    @(negedge clk);
    op = o; wr_data = w; channel = ch; start = 1'b1;
    cyc = 0; lows = 0; falls = 0; other = 1'b0; p = dsn_out[1];
    while (cyc < budget && !done) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2 && !hold) start = 1'b0;
      lows += int'(!dsn_out[1]);
      falls += int'(p && !dsn_out[1]);
      p = dsn_out[1];
      if (!dsn_out[0] || !dsn_out[2]) other = 1'b1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout op %0d: no done within %0d cycles", o, budget);
    end
    if (!hold) start = 1'b0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int cyc, lows, falls;
    bit other, bad;
    rst_n = 1'b0; start = 1'b0; op = 2'd0; wr_data = 1'b0; channel = 2'd0;
    repeat (3) @(negedge clk);
    chk("reset dsn_out", 64'(dsn_out), 64'h7);
    chk("reset flags", 64'({busy, done, rd_data, present, crc_ok, sel_err}), 64'd0);
    chk("reset rom_data", rom_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chip_en = 1'b1;
    push("rom", 1'b1, 1'b1, 1'b1, 1'b0, ROM);
    run_op(2'd3, 1'b0, 2'd1, 6000, 1'b0, cyc, lows, falls, other);
    chk("rom command bits", 64'(cmd), 64'h33);
    chk("rom line falls", 64'(falls), 64'd73);
    chk("rom other channels", 64'(other), 64'd0);
    rom_m = ROM ^ (64'd1 << 20);
    push("rom flip", 1'b1, 1'b1, 1'b0, 1'b0, ROMF);
    run_op(2'd3, 1'b0, 2'd1, 6000, 1'b0, cyc, lows, falls, other);
    chip_en = 1'b0;
    rom_m = ROM;
    push("rom nopres", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    run_op(2'd3, 1'b0, 2'd1, 1000, 1'b0, cyc, lows, falls, other);
    chk("nopres duration", 64'(cyc), 64'd257);
    chk("nopres line falls", 64'(falls), 64'd1);
    push("wr0", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    run_op(2'd1, 1'b0, 2'd1, 200, 1'b0, cyc, lows, falls, other);
    chk("wr0 low clocks", 64'(lows), 64'd16);
    chk("wr0 slot clocks", 64'(cyc), 64'd34);
    push("wr1", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    run_op(2'd1, 1'b1, 2'd1, 200, 1'b0, cyc, lows, falls, other);
    chk("wr1 low clocks", 64'(lows), 64'd4);
    chk("wr1 slot clocks", 64'(cyc), 64'd34);
    push("rd released", 1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    run_op(2'd2, 1'b0, 2'd1, 200, 1'b0, cyc, lows, falls, other);
    hold_low = 1'b1;
    push("rd held", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    run_op(2'd2, 1'b0, 2'd1, 200, 1'b0, cyc, lows, falls, other);
    hold_low = 1'b0;
    chip_en = 1'b1;
    push("init", 1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
    run_op(2'd0, 1'b0, 2'd1, 1000, 1'b0, cyc, lows, falls, other);
    chk("init duration", 64'(cyc), 64'd257);
    chip_en = 1'b0;
    push("sel err", 1'b0, 1'b1, 1'b0, 1'b1, 64'd0);
    run_op(2'd3, 1'b0, 2'd3, 10, 1'b1, cyc, lows, falls, other);
    chk("sel err latency", 64'(cyc), 64'd1);
    chk("sel err line", 64'({other, lows != 0}), 64'd0);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy || dsn_out != 3'b111) bad = 1'b1;
    end
    chk("start held no retrigger", 64'(bad), 64'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    op = 2'd1; wr_data = 1'b0; channel = 2'd1; start = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid slot line low", 64'(dsn_out), 64'h5);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset release", 64'(dsn_out), 64'h7);
    chk("async reset busy", 64'(busy), 64'd0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post reset line", 64'(dsn_out), 64'h7);
    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk + m_chk, n_fail + m_fail);
    $finish;
  end
endmodule
